// File: rtl/ovl_change_stim_pkg.sv
// Shared types and helpers for the change-checker stimulus generator: FSM states,
// offset-field width and the reference verdict on whether the checker must fire.
`ifndef OVL_IGNORE_NEW_START
`define OVL_IGNORE_NEW_START 0
`endif
`ifndef OVL_RESET_ON_NEW_START
`define OVL_RESET_ON_NEW_START 1
`endif
`ifndef OVL_ERROR_ON_NEW_START
`define OVL_ERROR_ON_NEW_START 2
`endif

package ovl_change_stim_pkg;

    typedef enum logic [1:0] {IDLE, START, WIN, DONE} state_t;

    function automatic int cw_width(input int num_cks);
        return $clog2(2 * num_cks + 2);
    endfunction

    // A restart under RESET_ON_NEW_START opens a fresh window r+1..r+num_cks.
    function automatic logic calc_expect_fire(input int action, input int num_cks,
                                              input int change_at, input int restart_at,
                                              input logic delta_nz);
        logic restart_ok;
        logic resets;
        logic effective;
        int   len;
        int   lo;
        restart_ok = (restart_at >= 1) && (restart_at <= num_cks);
        resets     = restart_ok && (action == `OVL_RESET_ON_NEW_START);
        len        = resets ? restart_at + num_cks : num_cks;
        lo         = resets ? restart_at + 1 : 1;
        effective  = delta_nz && (change_at >= 1) && (change_at <= len);
        if (restart_ok && (action == `OVL_ERROR_ON_NEW_START))
            return 1'b1;
        return !(effective && (change_at >= lo) && (change_at <= lo + num_cks - 1));
    endfunction

endpackage

// File: rtl/change_stim_window_ctr.sv
// Loadable sequence cycle counter; saturates at len+1 and flags window (1..len) and the last window cycle.
// Zero latency on flags: they decode the registered count directly.
module change_stim_window_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] len,
    output logic [CW-1:0] cnt,
    output logic          window,
    output logic          last_cycle
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && (cnt <= len))
            cnt <= cnt + 1'b1;
    end

    assign window     = (cnt != '0) && (cnt <= len);
    assign last_cycle = (cnt == len);

endmodule

// File: rtl/ovl_change_stim_gen.sv
// Drives start_event/test_expr into a change checker, one command per sequence, and reports the expected verdict.
// Command accepted only in IDLE; start at A+1, done at L+1, ready again at L+2.
module ovl_change_stim_gen
    import ovl_change_stim_pkg::*;
#(
    parameter int width               = 8,
    parameter int num_cks             = 2,
    parameter int action_on_new_start = `OVL_IGNORE_NEW_START,
    parameter int CW                  = cw_width(num_cks)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CW-1:0]    cmd_change_at,
    input  logic [CW-1:0]    cmd_restart_at,
    input  logic [width-1:0] cmd_delta,
    output logic             start_event,
    output logic [width-1:0] test_expr,
    output logic             window,
    output logic             busy,
    output logic             done,
    output logic             expect_fire
);

    localparam logic [CW-1:0] NUM_CKS = CW'(num_cks);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cap_change;
    logic [CW-1:0]    cap_restart;
    logic [width-1:0] cap_delta;
    logic [CW-1:0]    seq_len;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic             accept;
    logic             restart_ok;
    logic             change_ok;
    logic             active;
    logic             last_cycle;

    assign cmd_ready  = (state == IDLE) && !reset;
    assign accept     = cmd_valid && cmd_ready;
    assign restart_ok = (cap_restart != '0) && (cap_restart <= NUM_CKS);
    assign seq_len    = (restart_ok && (action_on_new_start == `OVL_RESET_ON_NEW_START))
                        ? cap_restart + NUM_CKS : NUM_CKS;
    assign change_ok  = (cap_change != '0) && (cap_change <= seq_len);
    assign active     = (state == START) || (state == WIN);
    assign cnt_inc    = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_change  <= '0;
            cap_restart <= '0;
            cap_delta   <= '0;
        end else if (accept) begin
            cap_change  <= cmd_change_at;
            cap_restart <= cmd_restart_at;
            cap_delta   <= cmd_delta;
        end
    end

    change_stim_window_ctr #(.CW(CW)) u_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .en         (state != IDLE),
        .len        (seq_len),
        .cnt        (cnt),
        .window     (window),
        .last_cycle (last_cycle)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept)
                    state_nxt = START;
            end
            START: state_nxt = WIN;
            WIN: begin
                if (last_cycle)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so decide from the cycle number about to begin (cnt_inc).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_event <= 1'b0;
            test_expr   <= '0;
        end else begin
            start_event <= accept || (active && restart_ok && (cnt_inc == cap_restart));
            if (active && change_ok && (cnt_inc == cap_change))
                test_expr <= test_expr ^ cap_delta;
        end
    end

    assign expect_fire = done && calc_expect_fire(action_on_new_start, num_cks,
                                                  int'(cap_change), int'(cap_restart),
                                                  |cap_delta);

endmodule
